// File: rtl/calc_result_display.sv
// calc_result_display: converts an 8-bit unsigned result to three BCD digits
// by double-dabble (8 cycles per conversion). It also scans the digits onto a
// multiplexed 7-segment display.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   result_i     unsigned value to convert
//   load_i       one-cycle capture strobe; ignored while busy_o is high
//   busy_o       conversion in progress
//   valid_o      bcd_o holds a completed conversion
//   bcd_o        {hundreds, tens, ones} BCD digits
//   seg_o        active-high segments of the scanned digit (bit0=a .. bit6=g)
//   dig_en_o     one-hot digit enable: 001 ones, 010 tens, 100 hundreds
//
// Build option: define CALC_RESULT_DISPLAY_LZB_EN to blank leading zeros.
module calc_result_display #(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  result_i,
  input  logic        load_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [11:0] bcd_o,
  output logic [6:0]  seg_o,
  output logic [2:0]  dig_en_o
);

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIG_N  = 3;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned SCAN_W = 16;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(BIN_W - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t              r_state, w_state_nxt;
  logic [BIN_W-1:0]    r_bin, w_bin_nxt;
  logic [BCD_W-1:0]    r_work, w_work_nxt, w_work_adj;
  logic [BCD_W-1:0]    r_bcd, w_bcd_nxt;
  logic [STEP_W-1:0]   r_step, w_step_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_valid, w_valid_nxt;
  logic [SCAN_W-1:0]   r_scan;
  logic [DIG_N-1:0]    r_dig;
  logic [3:0]          w_digit;
  logic [SEG_W-1:0]    w_seg_raw;
  logic                w_blank;

  // Double-dabble correction: add 3 to every working digit >= 5
  always_comb begin
    w_work_adj = r_work;
    for (int i = 0; i < int'(DIG_N); i++) begin
      if (r_work[4*i +: 4] >= 4'd5) begin
        w_work_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_nxt = r_state;
    w_bin_nxt   = r_bin;
    w_work_nxt  = r_work;
    w_bcd_nxt   = r_bcd;
    w_step_nxt  = r_step;
    w_busy_nxt  = r_busy;
    w_valid_nxt = r_valid;
    case (r_state)
      IDLE: begin
        if (load_i) begin
          w_bin_nxt   = result_i;
          w_work_nxt  = '0;
          w_step_nxt  = '0;
          w_busy_nxt  = 1'b1;
          w_valid_nxt = 1'b0;
          w_state_nxt = CONV;
        end
      end
      CONV: begin
        {w_work_nxt, w_bin_nxt} = {w_work_adj[BCD_W-2:0], r_bin, 1'b0};
        w_step_nxt = r_step + STEP_W'(1);
        if (r_step == LAST_STEP) begin
          // Final shift lands directly in the output register
          w_bcd_nxt   = {w_work_adj[BCD_W-2:0], r_bin[BIN_W-1]};
          w_busy_nxt  = 1'b0;
          w_valid_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin   <= '0;
      r_work  <= '0;
      r_bcd   <= '0;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_bin   <= w_bin_nxt;
      r_work  <= w_work_nxt;
      r_bcd   <= w_bcd_nxt;
      r_step  <= w_step_nxt;
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Free-running digit scan, rotates the enable on each counter wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_dig  <= 3'b001;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_dig  <= {r_dig[1:0], r_dig[2]};
    end else begin
      r_scan <= r_scan + SCAN_W'(1);
    end
  end

  // Select the scanned digit and decide on leading-zero blanking
  always_comb begin
    w_digit = r_bcd[3:0];
    w_blank = 1'b0;
    case (r_dig)
      3'b010: begin
        w_digit = r_bcd[7:4];
`ifdef CALC_RESULT_DISPLAY_LZB_EN
        w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
`endif
      end
      3'b100: begin
        w_digit = r_bcd[11:8];
`ifdef CALC_RESULT_DISPLAY_LZB_EN
        w_blank = (r_bcd[11:8] == 4'd0);
`endif
      end
      default: w_digit = r_bcd[3:0];
    endcase
  end

  // 7-segment decode; codes 10..15 never occur and show nothing
  always_comb begin
    w_seg_raw = '0;
    case (w_digit)
      4'd0:    w_seg_raw = 7'h3F;
      4'd1:    w_seg_raw = 7'h06;
      4'd2:    w_seg_raw = 7'h5B;
      4'd3:    w_seg_raw = 7'h4F;
      4'd4:    w_seg_raw = 7'h66;
      4'd5:    w_seg_raw = 7'h6D;
      4'd6:    w_seg_raw = 7'h7D;
      4'd7:    w_seg_raw = 7'h07;
      4'd8:    w_seg_raw = 7'h7F;
      4'd9:    w_seg_raw = 7'h6F;
      default: w_seg_raw = 7'h00;
    endcase
  end

  always_comb begin
    seg_o = '0;
    if (r_valid && !w_blank) seg_o = w_seg_raw;
  end

  assign busy_o   = r_busy;
  assign valid_o  = r_valid;
  assign bcd_o    = r_bcd;
  assign dig_en_o = r_dig;

endmodule

// File: doc/calc_result_display.md
CALC_RESULT_DISPLAY -- requirements
Module: calc_result_display

Interface
REQ-001 Parameter SCAN_DIV, default 1024, SHALL set the clock cycles each digit is enabled; legal range 2..65535.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 result_i  input  8  SHALL be the unsigned calculator result to display.
REQ-005 load_i  input  1  SHALL be the one-cycle strobe requesting capture of result_i.
REQ-006 busy_o  output  1  SHALL be high while a conversion is in progress.
REQ-007 valid_o  output  1  SHALL be high while bcd_o holds a completed conversion.
REQ-008 bcd_o  output  12  SHALL carry hundreds [11:8], tens [7:4] and ones [3:0] BCD digits.
REQ-009 seg_o  output  7  SHALL drive active-high segments, bit0=a .. bit6=g.
REQ-010 dig_en_o  output  3  SHALL be a one-hot digit enable: 001 ones, 010 tens, 100 hundreds.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and CONV.
REQ-012 In IDLE, load_i=1 at an edge SHALL capture result_i, clear the BCD working register, clear valid_o, set busy_o and enter CONV.
REQ-013 In CONV, each edge SHALL add 3 to every working BCD digit >=5, then shift {bcd,binary} left one bit (double-dabble).
REQ-014 Conversion SHALL take exactly 8 CONV edges; at load edge k the 8th CONV edge is k+8, at which bcd_o is updated, valid_o=1, busy_o=0 and the FSM returns to IDLE.
REQ-015 load_i while busy_o=1 SHALL be ignored, with no effect on the conversion in progress.
REQ-016 bcd_o SHALL hold its previous value during CONV and change only at completion.
REQ-017 A 16-bit scan counter SHALL count 0..SCAN_DIV-1 and wrap; on the wrap edge dig_en_o SHALL rotate 001->010->100->001.
REQ-018 Scanning SHALL run continuously, independent of FSM state and load_i.
REQ-019 seg_o SHALL be the combinational decode of the selected digit: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex).
REQ-020 Digit codes 10..15 SHALL decode to 00 (unreachable; hundreds <=2 for all inputs).
REQ-021 seg_o SHALL be 00 whenever valid_o=0.

Reset
REQ-022 rst_n low SHALL force, asynchronously: state IDLE, busy_o=0, valid_o=0, bcd_o=000, scan counter 0, dig_en_o=001, seg_o=00.
REQ-023 Reset asserted mid-conversion SHALL abandon it; after release the block waits in IDLE for a new load_i.
REQ-024 The first load_i is honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro CALC_RESULT_DISPLAY_LZB_EN SHALL, when defined, enable leading-zero blanking: hundreds blanked (seg_o=00) if 0; tens blanked if hundreds and tens both 0; ones never blanked.
REQ-026 Without CALC_RESULT_DISPLAY_LZB_EN, all three digits SHALL display including leading zeros; bcd_o is identical in both builds.

Verification
REQ-027 Reset, load result_i=255 -> busy_o high edges k..k+7, at edge k+8 bcd_o=255h (0x255), valid_o=1, busy_o=0.
REQ-028 load result_i=0 -> bcd_o=000h; ones digit shows seg_o=3F; hundreds/tens show 3F (macro off) or 00 (macro on).
REQ-029 load 7, then load 200 at edge k+3 -> second load ignored, bcd_o=007h at k+8; a new load after completion gives 200h.
REQ-030 SCAN_DIV=4, valid 128 (bcd 128h) -> dig_en_o changes every 4 cycles 001,010,100,001; seg_o 7F,5B,06 in turn.
REQ-031 load 99, assert rst_n low at edge k+4 -> all outputs at REQ-022 values immediately; after release, bcd_o stays 000, valid_o=0 until next load.
REQ-032 Exhaustive sweep result_i 0..255 -> bcd_o equals decimal value of result_i for every input.
